// File: rtl/digit_serial_add.sv
// Digit-serial unsigned adder: walks 2-bit digits of a and b through an external 2-bit full adder, LSD first.
// Optional macro DIGIT_SERIAL_ADD_OVF_EN adds a two's-complement overflow flag output (ovf).
module digit_serial_add #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2*DIGITS-1:0] a,
  input  logic [2*DIGITS-1:0] b,
  input  logic                cin,
  output logic [1:0]          add_x,
  output logic [1:0]          add_y,
  output logic                add_cin,
  input  logic [1:0]          add_s,
  input  logic                add_cout,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*DIGITS-1:0] sum,
  output logic                cout
`ifdef DIGIT_SERIAL_ADD_OVF_EN
  ,
  output logic                ovf
`endif
);

  localparam int W  = 2 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        state;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;
  logic          carry;
  logic [IW-1:0] idx;
  logic [IW:0]   bit_pos;

  // Bit offset of the current digit, i.e. 2*idx.
  assign bit_pos = {idx, 1'b0};

  // The external adder only sees live operands while a digit is being processed.
  always_comb begin
    add_x   = 2'b00;
    add_y   = 2'b00;
    add_cin = 1'b0;
    if (state == RUN) begin
      add_x   = a_reg[bit_pos +: 2];
      add_y   = b_reg[bit_pos +: 2];
      add_cin = carry;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      carry     <= 1'b0;
      idx       <= '0;
      sum       <= '0;
      cout      <= 1'b0;
`ifdef DIGIT_SERIAL_ADD_OVF_EN
      ovf       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg    <= a;
            b_reg    <= b;
            carry    <= cin;
            idx      <= '0;
            sum      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          sum[bit_pos +: 2] <= add_s;
          carry             <= add_cout;
          idx               <= idx + 1'b1;
          if (idx == LAST) begin
            cout      <= add_cout;
            out_valid <= 1'b1;
            state     <= DONE;
`ifdef DIGIT_SERIAL_ADD_OVF_EN
            // add_s[1] is the final sum MSB, written on this same edge.
            ovf       <= (a_reg[W-1] == b_reg[W-1]) && (add_s[1] != a_reg[W-1]);
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_digit_serial_add.sv
// Scoreboard bench for digit_serial_add (DIGITS=4) with a behavioural 2-bit adder closing the loop.
module tb_digit_serial_add;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       cin = 1'b0;
  logic [1:0] add_x, add_y, add_s;
  logic       add_cin, add_cout;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] sum;
  logic       cout;
`ifdef DIGIT_SERIAL_ADD_OVF_EN
  logic       ovf;
`endif

  typedef struct {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } exp_t;

  exp_t sb_q[$];
  int   accept_q[$];
  int   cyc = 0;
  int   compared = 0;
  int   failed = 0;
  logic prev_valid = 1'b0;
  int   acc_c;
  exp_t exp_item;

  digit_serial_add #(.DIGITS(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
    .add_x(add_x), .add_y(add_y), .add_cin(add_cin),
    .add_s(add_s), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout)
`ifdef DIGIT_SERIAL_ADD_OVF_EN
    , .ovf(ovf)
`endif
  );

  assign {add_cout, add_s} = 3'(add_x) + 3'(add_y) + 3'(add_cin);

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: latency on each out_valid rise, result contents on each output handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && !prev_valid) begin
        if (accept_q.size() > 0) begin
          acc_c = accept_q.pop_front();
          checkOutput("latency", 32'(cyc - acc_c - 1), 32'd4);
        end else begin
          compared++;
          failed++;
          $display("[TB] FAIL unexpected_out_valid: got 1 expected 0");
        end
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          compared++;
          failed++;
          $display("[TB] FAIL unexpected_result: got sum 0x%0h expected none", sum);
        end else begin
          exp_item = sb_q.pop_front();
          checkOutput("sum", 32'(sum), 32'(exp_item.sum));
          checkOutput("cout", 32'(cout), 32'(exp_item.cout));
`ifdef DIGIT_SERIAL_ADD_OVF_EN
          checkOutput("ovf", 32'(ovf), 32'(exp_item.ovf));
`endif
        end
      end
      if (in_valid && in_ready) accept_q.push_back(cyc);
    end
    prev_valid = out_valid;
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic applyStimulus(input logic [7:0] va, input logic [7:0] vb, input logic vc,
                               input logic [7:0] es, input logic ec, input logic eo, input bit track);
    int waited = 0;
    while (!in_ready && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) begin
      compared++;
      failed++;
      $display("[TB] FAIL accept_timeout: got in_ready 0 expected 1");
      return;
    end
    a = va; b = vb; cin = vc; in_valid = 1'b1;
    if (track) sb_q.push_back('{es, ec, eo});
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = ~va; b = vb ^ 8'h5A; cin = ~vc;
  endtask

  task automatic waitDrain();
    int n = 0;
    while (sb_q.size() > 0 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("drain", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int last;
    int count;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_sum", 32'(sum), 32'd0);
    checkOutput("rst_cout", 32'(cout), 32'd0);
    checkOutput("rst_add_x", 32'(add_x), 32'd0);
    checkOutput("rst_add_y", 32'(add_y), 32'd0);
    checkOutput("rst_add_cin", 32'(add_cin), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    applyStimulus(8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b1, 1'b1);
    waitDrain();
    applyStimulus(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    waitDrain();
    applyStimulus(8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1);
    waitDrain();

    // Result must hold while the consumer stalls and the inputs churn.
    out_ready = 1'b0;
    applyStimulus(8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 20 && !out_valid; i++) begin
      @(posedge clk); #1;
    end
    for (int i = 0; i < 5; i++) begin
      a = 8'(i * 37); b = ~a; cin = i[0]; in_valid = i[0];
      checkOutput("hold_sum", 32'(sum), 32'h47);
      checkOutput("hold_cout", 32'(cout), 32'd0);
      checkOutput("hold_in_ready", 32'(in_ready), 32'd0);
      checkOutput("hold_out_valid", 32'(out_valid), 32'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("release_in_ready", 32'(in_ready), 32'd1);
    checkOutput("release_out_valid", 32'(out_valid), 32'd0);
    waitDrain();

    // Abort during the second RUN cycle.
    applyStimulus(8'hAB, 8'hCD, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checkOutput("abort_in_ready", 32'(in_ready), 32'd1);
    checkOutput("abort_out_valid", 32'(out_valid), 32'd0);
    checkOutput("abort_sum", 32'(sum), 32'd0);
    checkOutput("abort_cout", 32'(cout), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    accept_q.delete();
    applyStimulus(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0, 1'b1);
    waitDrain();

    // Continuous requests: one acceptance every DIGITS+2 cycles.
    last = -1;
    count = 0;
    a = 8'h21; b = 8'h10; cin = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 25; i++) begin
      if (in_ready) begin
        sb_q.push_back('{8'h31, 1'b0, 1'b0});
        if (last >= 0) checkOutput("period", 32'(i - last), 32'd6);
        last = i;
        count++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checkOutput("accept_count", 32'(count), 32'd5);
    waitDrain();

`ifdef DIGIT_SERIAL_ADD_OVF_EN
    applyStimulus(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b1);
    waitDrain();
    applyStimulus(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
    waitDrain();
`endif

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
